// File: rtl/run_expander.sv
// -----------------------------------------------------------------------------
// run_expander
//
// Streaming run-length expander. Accepts (byte, run) pairs and re-emits each
// byte `run` times, packed into N-byte words. Lane 0 (out_data[7:0]) carries
// the earliest byte in stream order. Unused lanes of a word are zero.
// out_count gives the number of valid lanes. A frame ends with a word flagged
// out_last; an empty frame yields a single word with out_count = 0.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (discards everything in flight)
//   in_valid   input pair present
//   in_ready   block can accept a pair (only in IDLE, low while rst is high)
//   in_data    byte value
//   in_run     number of copies, 0 means emit nothing
//   in_last    final pair of the frame
//   out_valid  output word present (held until out_ready)
//   out_ready  consumer accepts the word
//   out_data   packed bytes, lane i = out_data[8*(i+1)-1 -: 8]
//   out_count  number of valid lanes (0..N)
//   out_last   final word of the frame
// -----------------------------------------------------------------------------
module run_expander #(
   parameter int N  = 8,
   parameter int CW = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [7:0]                 in_data,
   input  logic [CW-1:0]              in_run,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [8*N-1:0]             out_data,
   output logic [$clog2(N+1)-1:0]     out_count,
   output logic                       out_last
);

   localparam int FW = $clog2(N+1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   state_t           state;
   logic [8*N-1:0]   asm_data;   // assembly register; lanes at/above fill are always zero
   logic [FW-1:0]    fill;
   logic [CW-1:0]    remaining;
   logic [7:0]       byte_l;
   logic             last_l;

   logic             out_free;
   logic             full;
   logic             xfer_full;
   logic             xfer_flush;
   logic             transfer;
   logic             write_en;
   logic             accept;
   logic [8*N-1:0]   asm_nxt;
   logic [FW-1:0]    fill_nxt;

   // Write one byte into a lane of a packed word.
   function automatic logic [8*N-1:0] put_lane(input logic [8*N-1:0] w,
                                               input logic [FW-1:0]  lane,
                                               input logic [7:0]     b);
      logic [8*N-1:0] r;
      r = w;
      r[8*int'(lane) +: 8] = b;
      return r;
   endfunction

   assign in_ready = (state == IDLE) && !rst;
   assign accept   = in_valid && in_ready;
   assign out_free = !out_valid || out_ready;
   assign full     = (fill == FW'(N));

   // A full word leaves eagerly whenever the output register can take it,
   // except in FLUSH where the same word goes out flagged as last instead.
   assign xfer_full  = full && out_free && (state != FLUSH);
   assign xfer_flush = (state == FLUSH) && out_free;
   assign transfer   = xfer_full || xfer_flush;

   // EXPAND writes unless the assembly is full and cannot be emptied this cycle.
   assign write_en = (state == EXPAND) && (!full || out_free);

   // ---- assembly next-state: transfer clears first, then the write lands ----
   always_comb begin
      asm_nxt  = asm_data;
      fill_nxt = fill;
      if (transfer) begin
         asm_nxt  = '0;
         fill_nxt = '0;
      end
      if (write_en) begin
         asm_nxt  = put_lane(asm_nxt, fill_nxt, byte_l);
         fill_nxt = fill_nxt + FW'(1);
      end
   end

   // ---- control FSM, assembly and output register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         asm_data  <= '0;
         fill      <= '0;
         remaining <= '0;
         byte_l    <= '0;
         last_l    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_last  <= 1'b0;
      end else begin
         asm_data <= asm_nxt;
         fill     <= fill_nxt;

         if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= asm_data;
            out_count <= fill;
            out_last  <= xfer_flush;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  byte_l    <= in_data;
                  remaining <= in_run;
                  last_l    <= in_last;
                  if (in_run != '0) begin
                     state <= EXPAND;
                  end else if (in_last) begin
                     state <= FLUSH;
                  end
               end
            end
            EXPAND: begin
               if (write_en) begin
                  remaining <= remaining - CW'(1);
                  if (remaining == CW'(1)) begin
                     state <= last_l ? FLUSH : IDLE;
                  end
               end
            end
            FLUSH: begin
               if (out_free) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
